// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver and its FIFO users.
package uart_pkg;
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP1 = 3'd4,
        ST_STOP2 = 3'd5
    } rx_state_e;

    // Status word layout: {BRK, FERR, PERR, DATA[dbits-1:0]}.
    function automatic int status_width(input int dbits);
        return dbits + 3;
    endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO with extra-MSB pointers; head word is valid whenever not empty.
module uart_sync_fifo #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic         clk_i,
    input  logic         arst_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int DEPTH = 2 ** AW;

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic         do_push;
    logic         do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide what is visible.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/uart_rx_ovs.sv
// UART receiver with 3-sample majority voting, parity/framing/break detection and an output FIFO.
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int C_F_CK    = 135_000_000,
    parameter int C_BAUD    = 115_200,
    parameter int C_DBITS   = 8,
    parameter int C_PAR     = 0,
    parameter int C_STOP    = 1,
    parameter int C_FIFO_AW = 3
) (
    input  logic               CK_i,
    input  logic               ARST_i,
    input  logic               RXD_i,
    output logic [C_DBITS-1:0] DATA_o,
    output logic               PERR_o,
    output logic               FERR_o,
    output logic               BRK_o,
    output logic               VALID_o,
    input  logic               READY_i,
    output logic               OVR_o,
    input  logic               CLR_i,
    output logic               BUSY_o
);
    localparam int C_BAUD_N = C_F_CK / C_BAUD;
    localparam int C_MID    = C_BAUD_N / 2;
    localparam int CW       = $clog2(C_BAUD_N);
    localparam int SW       = status_width(C_DBITS);

    localparam logic [CW-1:0] CTR_LAST = CW'(C_BAUD_N - 1);
    localparam logic [CW-1:0] CTR_S0   = CW'(C_MID - 1);
    localparam logic [CW-1:0] CTR_S1   = CW'(C_MID);
    localparam logic [CW-1:0] CTR_S2   = CW'(C_MID + 1);
    localparam logic [3:0]    IDX_LAST = 4'(C_DBITS - 1);

    if (C_BAUD_N < 8) begin : g_bad_baud
        $error("uart_rx_ovs: C_F_CK/C_BAUD must be at least 8");
    end
    if (C_DBITS < 5 || C_DBITS > 9) begin : g_bad_dbits
        $error("uart_rx_ovs: C_DBITS must be 5..9");
    end
    if (C_STOP < 1 || C_STOP > 2) begin : g_bad_stop
        $error("uart_rx_ovs: C_STOP must be 1 or 2");
    end

    logic [1:0]         sync_q;
    logic               rxs;
    logic               rxs_prev_q;
    rx_state_e          state_q;
    logic [CW-1:0]      ctr_q;
    logic [1:0]         smp_q;
    logic [3:0]         bit_idx_q;
    logic [C_DBITS-1:0] shift_q;
    logic               par_q;
    logic               perr_q;
    logic               ferr_q;
    logic               zero_q;
    logic               hold_q;
    logic               push_q;
    logic [SW-1:0]      word_q;
    logic               ovr_q;

    logic               maj;
    logic               decide;
    logic               finish;
    logic               fin_ferr;
    logic               fin_brk;

    logic [SW-1:0]      fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic [SW-1:0]      head;

    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], RXD_i};
    end
    assign rxs = sync_q[1];

    always_comb begin
        // NOTE: every combinational output is given a default first, so no path infers a latch.
        maj      = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);
        decide   = (ctr_q == CTR_S2);
        fin_brk  = zero_q & ~maj;
        fin_ferr = ~maj;
        finish   = 1'b0;
        if (decide && state_q == ST_STOP2) begin
            fin_ferr = ferr_q | ~maj;
            finish   = 1'b1;
        end
        if (decide && state_q == ST_STOP1 && C_STOP == 1) finish = 1'b1;
    end

    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            state_q    <= ST_IDLE;
            ctr_q      <= '0;
            smp_q      <= 2'b11;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            zero_q     <= 1'b0;
            hold_q     <= 1'b0;
            rxs_prev_q <= 1'b1;
            push_q     <= 1'b0;
            word_q     <= '0;
        end else begin
            push_q     <= 1'b0;
            rxs_prev_q <= rxs;
            if (state_q != ST_IDLE) begin
                ctr_q <= (ctr_q == CTR_LAST) ? '0 : ctr_q + 1'b1;
                if (ctr_q == CTR_S0) smp_q[0] <= rxs;
                if (ctr_q == CTR_S1) smp_q[1] <= rxs;
            end
            unique case (state_q)
                ST_IDLE: begin
                    // After a framing error the line must go high again before a start edge counts.
                    if (hold_q) begin
                        if (rxs) hold_q <= 1'b0;
                    end else if (rxs_prev_q && !rxs) begin
                        state_q <= ST_START;
                        ctr_q   <= '0;
                    end
                end
                ST_START: begin
                    if (decide) begin
                        if (maj) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q   <= ST_DATA;
                            bit_idx_q <= '0;
                            par_q     <= 1'b0;
                            perr_q    <= 1'b0;
                            ferr_q    <= 1'b0;
                            zero_q    <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (decide) begin
                        shift_q <= {maj, shift_q[C_DBITS-1:1]};
                        par_q   <= par_q ^ maj;
                        zero_q  <= zero_q & ~maj;
                        if (bit_idx_q == IDX_LAST)
                            state_q <= (C_PAR != PAR_NONE) ? ST_PAR : ST_STOP1;
                        else
                            bit_idx_q <= bit_idx_q + 1'b1;
                    end
                end
                ST_PAR: begin
                    if (decide) begin
                        perr_q  <= (C_PAR == PAR_ODD) ? ~(par_q ^ maj) : (par_q ^ maj);
                        zero_q  <= zero_q & ~maj;
                        state_q <= ST_STOP1;
                    end
                end
                ST_STOP1: begin
                    if (decide && C_STOP == 2) begin
                        ferr_q  <= ~maj;
                        zero_q  <= fin_brk;
                        state_q <= ST_STOP2;
                    end
                end
                ST_STOP2: begin
                end
                default: state_q <= ST_IDLE;
            endcase
            if (finish) begin
                push_q  <= 1'b1;
                word_q  <= {fin_brk, fin_ferr, perr_q, shift_q};
                hold_q  <= fin_ferr;
                state_q <= ST_IDLE;
            end
        end
    end

    assign BUSY_o  = (state_q != ST_IDLE);
    assign VALID_o = ~fifo_empty;
    assign pop     = VALID_o & READY_i;

    uart_sync_fifo #(
        .W  (SW),
        .AW (C_FIFO_AW)
    ) u_fifo (
        .clk_i   (CK_i),
        .arst_i  (ARST_i),
        .push_i  (push_q),
        .wdata_i (word_q),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Overrun wins over a simultaneous clear.
    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i)                            ovr_q <= 1'b0;
        else if (push_q && fifo_full && !pop)  ovr_q <= 1'b1;
        else if (CLR_i)                        ovr_q <= 1'b0;
    end
    assign OVR_o = ovr_q;

    assign head = fifo_empty ? '0 : fifo_rdata;
    assign {BRK_o, FERR_o, PERR_o, DATA_o} = head;
endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed scoreboard bench for uart_rx_ovs (N=10 clocks per bit, 8N1 and 8E1 instances).
module tb_uart_rx_ovs;
    logic       clk;
    logic       rst;
    logic       rxd, rxd_p;
    logic       ready, ready_p;
    logic       clr, clr_p;
    logic [7:0] data, data_p;
    logic       perr, ferr, brk, valid, ovr, busy;
    logic       perr_p, ferr_p, brk_p, valid_p, ovr_p, busy_p;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_start  = 0;
    int t_first_valid = -1;
    int lat;

    logic [31:0] sb   [$];
    logic [31:0] sb_p [$];

    uart_rx_ovs #(
        .C_F_CK(1000), .C_BAUD(100), .C_DBITS(8), .C_PAR(0), .C_STOP(1), .C_FIFO_AW(3)
    ) u_dut (
        .CK_i(clk), .ARST_i(rst), .RXD_i(rxd), .DATA_o(data), .PERR_o(perr),
        .FERR_o(ferr), .BRK_o(brk), .VALID_o(valid), .READY_i(ready),
        .OVR_o(ovr), .CLR_i(clr), .BUSY_o(busy)
    );

    uart_rx_ovs #(
        .C_F_CK(1000), .C_BAUD(100), .C_DBITS(8), .C_PAR(1), .C_STOP(1), .C_FIFO_AW(3)
    ) u_dut_par (
        .CK_i(clk), .ARST_i(rst), .RXD_i(rxd_p), .DATA_o(data_p), .PERR_o(perr_p),
        .FERR_o(ferr_p), .BRK_o(brk_p), .VALID_o(valid_p), .READY_i(ready_p),
        .OVR_o(ovr_p), .CLR_i(clr_p), .BUSY_o(busy_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_word(input logic b, input logic f, input logic p,
                                            input logic [7:0] d);
        return {21'b0, b, f, p, d};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare any word being popped at the falling edge, then step past the rising edge.
    task automatic tick();
        @(negedge clk);
        if (!rst) begin
            if (valid && t_first_valid < 0) t_first_valid = cyc;
            if (valid && ready) begin
                n_assert++;
                assert (sb.size() != 0) else begin
                    n_fail++;
                    $error("FAIL spurious_word: observed 0x%0h expected none",
                           mk_word(brk, ferr, perr, data));
                end
                if (sb.size() != 0) check("rx_word", mk_word(brk, ferr, perr, data), sb.pop_front());
            end
            if (valid_p && ready_p) begin
                n_assert++;
                assert (sb_p.size() != 0) else begin
                    n_fail++;
                    $error("FAIL spurious_word_par: observed 0x%0h expected none",
                           mk_word(brk_p, ferr_p, perr_p, data_p));
                end
                if (sb_p.size() != 0)
                    check("rx_word_par", mk_word(brk_p, ferr_p, perr_p, data_p), sb_p.pop_front());
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) rxd_p = v;
        else     rxd   = v;
    endtask

    task automatic drive_bit(input bit sel, input logic v, input int spike);
        for (int c = 0; c < 10; c++) begin
            set_line(sel, (c == spike) ? ~v : v);
            tick();
        end
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                              input logic par_bit, input logic stop_bit, input int spike);
        drive_bit(sel, 1'b0, -1);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i], spike);
        if (has_par) drive_bit(sel, par_bit, -1);
        drive_bit(sel, stop_bit, -1);
        set_line(sel, 1'b1);
        ticks(3);
    endtask

    initial begin
        logic [7:0] pd;
        rst = 1'b1; rxd = 1'b1; rxd_p = 1'b1;
        ready = 1'b1; ready_p = 1'b1; clr = 1'b0; clr_p = 1'b0;
        @(posedge clk); #1;
        ticks(2);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_ovr",   32'(ovr),   32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        check("rst_head",  mk_word(brk, ferr, perr, data), 32'h0);
        check("rst_valid_par", 32'(valid_p), 32'h0);
        rst = 1'b0;
        ticks(3);

        // Two clean 8N1 frames, with first-word latency measured from the start edge.
        sb.push_back(mk_word(1'b0, 1'b0, 1'b0, 8'h55));
        sb.push_back(mk_word(1'b0, 1'b0, 1'b0, 8'hA3));
        t_start = cyc;
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, -1);
        send_frame(1'b0, 8'hA3, 1'b0, 1'b0, 1'b1, -1);
        ticks(20);
        lat = (t_first_valid < 0) ? -1 : t_first_valid - t_start;
        check("valid_latency_in_99_101", 32'(lat >= 99 && lat <= 101), 32'h1);
        check("ovr_after_clean", 32'(ovr), 32'h0);
        check("clean_words_seen", 32'(sb.size()), 32'h0);

        // Even parity: good and bad parity bit on 0x07.
        pd = 8'h07;
        sb_p.push_back(mk_word(1'b0, 1'b0, ^{pd, 1'b1}, pd));
        sb_p.push_back(mk_word(1'b0, 1'b0, ^{pd, 1'b0}, pd));
        send_frame(1'b1, pd, 1'b1, 1'b1, 1'b1, -1);
        send_frame(1'b1, pd, 1'b1, 1'b0, 1'b1, -1);
        ticks(20);
        check("parity_words_seen", 32'(sb_p.size()), 32'h0);
        check("parity_ovr", 32'(ovr_p), 32'h0);
        check("parity_busy", 32'(busy_p), 32'h0);

        // Framing error: stop bit forced low.
        sb.push_back(mk_word(1'b0, 1'b1, 1'b0, 8'h41));
        send_frame(1'b0, 8'h41, 1'b0, 1'b0, 1'b0, -1);
        ticks(20);
        check("ferr_word_seen", 32'(sb.size()), 32'h0);

        // Break: line low for 30 bit times gives exactly one word.
        sb.push_back(mk_word(1'b1, 1'b1, 1'b0, 8'h00));
        rxd = 1'b0;
        ticks(300);
        check("break_word_seen", 32'(sb.size()), 32'h0);
        check("break_idle_while_low", 32'(busy), 32'h0);
        rxd = 1'b1;
        ticks(50);
        check("break_no_extra", 32'(valid), 32'h0);

        // Three-clock glitch is a false start.
        rxd = 1'b0;
        ticks(3);
        rxd = 1'b1;
        ticks(2);
        check("glitch_busy", 32'(busy), 32'h1);
        ticks(20);
        check("glitch_back_idle", 32'(busy), 32'h0);
        check("glitch_no_word", 32'(valid), 32'h0);

        // One-clock spikes inside every data bit are voted out.
        sb.push_back(mk_word(1'b0, 1'b0, 1'b0, 8'hB6));
        sb.push_back(mk_word(1'b0, 1'b0, 1'b0, 8'h4D));
        send_frame(1'b0, 8'hB6, 1'b0, 1'b0, 1'b1, 5);
        send_frame(1'b0, 8'h4D, 1'b0, 1'b0, 1'b1, 4);
        ticks(20);
        check("spike_words_seen", 32'(sb.size()), 32'h0);

        // Overrun: 10 frames into a depth-8 FIFO with the consumer stalled.
        ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) sb.push_back(mk_word(1'b0, 1'b0, 1'b0, 8'(i)));
            send_frame(1'b0, 8'(i), 1'b0, 1'b0, 1'b1, -1);
        end
        ticks(20);
        check("ovr_set", 32'(ovr), 32'h1);
        check("ovr_valid", 32'(valid), 32'h1);
        check("ovr_head", mk_word(brk, ferr, perr, data), mk_word(1'b0, 1'b0, 1'b0, 8'h00));
        ticks(5);
        check("head_holds", 32'(data), 32'h0);
        ready = 1'b1;
        ticks(20);
        check("drain_all_seen", 32'(sb.size()), 32'h0);
        check("drain_empty", 32'(valid), 32'h0);
        check("ovr_sticky", 32'(ovr), 32'h1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("ovr_cleared", 32'(ovr), 32'h0);

        // Reset in the middle of data bit 4 with a word already waiting.
        ready = 1'b0;
        send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1, -1);
        ticks(10);
        check("pre_reset_valid", 32'(valid), 32'h1);
        pd = 8'h5A;
        drive_bit(1'b0, 1'b0, -1);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, pd[i], -1);
        rxd = pd[4];
        ticks(5);
        check("pre_reset_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(valid), 32'h0);
        check("mid_rst_head", mk_word(brk, ferr, perr, data), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_ovr", 32'(ovr), 32'h0);
        rxd = 1'b1;
        ticks(2);
        rst = 1'b0;
        ticks(200);
        check("post_rst_no_push", 32'(valid), 32'h0);
        ready = 1'b1;
        sb.push_back(mk_word(1'b0, 1'b0, 1'b0, 8'h3C));
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, -1);
        ticks(20);
        check("post_rst_word_seen", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
